// File: rtl/comparator_pkg.sv
// Shared types and helpers for the comparator_arbiter block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, and a width helper for requester indices.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESPOND = 2'd2
  } cmp_state_t;

  // Width of a requester index; never below one bit so a single-requester
  // build still has a legal vector.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comparator_eq.sv
// Unsigned equality of two Nbits operands.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: a_i, b_i - operands; eq_o - 1 when every bit of a_i matches b_i.
module comparator_eq #(
  parameter int Nbits = 16
) (
  input  logic [Nbits-1:0] a_i,
  input  logic [Nbits-1:0] b_i,
  output logic             eq_o
);

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/comparator_arbiter.sv
// Round-robin shares one registered equality comparator among NREQ requesters.
// Latency: accept edge t -> rsp_valid set on edge t+1; one transaction per 3 cycles.
// Backpressure: rsp_ready low holds RESPOND indefinitely; no req_ready is raised meanwhile.
//
// Ports: clock/reset_n (async active-low); req_valid/req_ready/req_a/req_b per
// requester (operands packed requester-major, Nbits each); rsp_valid/rsp_ready/
// rsp_id/rsp_equal result channel; busy = not IDLE; compare_count/equal_count
// saturating statistics.
module comparator_arbiter
  import comparator_pkg::*;
#(
  parameter int Nbits = 16,
  parameter int NREQ  = 4,
  parameter int CNTW  = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*Nbits-1:0]   req_a,
  input  logic [NREQ*Nbits-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [idw(NREQ)-1:0]    rsp_id,
  output logic                    rsp_equal,
  output logic                    busy,
  output logic [CNTW-1:0]         compare_count,
  output logic [CNTW-1:0]         equal_count
);

  localparam int IDW = idw(NREQ);

  cmp_state_t       state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [Nbits-1:0] op_a_q, op_a_d;
  logic [Nbits-1:0] op_b_q, op_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_equal_q, rsp_equal_d;
  logic [CNTW-1:0]  cmp_cnt_q, cmp_cnt_d;
  logic [CNTW-1:0]  eq_cnt_q, eq_cnt_d;

  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic             ops_equal;

  comparator_eq #(.Nbits(Nbits)) u_eq (
    .a_i  (op_a_q),
    .b_i  (op_b_q),
    .eq_o (ops_equal)
  );

  // Round-robin: first valid requester strictly after the previous winner,
  // wrapping, so the previous winner is considered last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant_q) + k) % NREQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_equal_d  = rsp_equal_q;
    cmp_cnt_d    = cmp_cnt_q;
    eq_cnt_d     = eq_cnt_q;
    req_ready    = '0;

    case (state_q)
      IDLE: begin
        // reset_n gates the accept so req_ready reads 0 while reset is held.
        if (grant_vld && reset_n) begin
          req_ready[grant_idx] = 1'b1;
          op_a_d       = req_a[int'(grant_idx)*Nbits +: Nbits];
          op_b_d       = req_b[int'(grant_idx)*Nbits +: Nbits];
          last_grant_d = grant_idx;
          state_d      = COMPARE;
        end
      end
      COMPARE: begin
        rsp_equal_d = ops_equal;
        rsp_id_d    = last_grant_q;
        rsp_valid_d = 1'b1;
        state_d     = RESPOND;
      end
      RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (cmp_cnt_q != {CNTW{1'b1}}) cmp_cnt_d = cmp_cnt_q + CNTW'(1);
          if (rsp_equal_q && (eq_cnt_q != {CNTW{1'b1}})) eq_cnt_d = eq_cnt_q + CNTW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);  // requester 0 wins first
      op_a_q       <= '0;
      op_b_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_equal_q  <= 1'b0;
      cmp_cnt_q    <= '0;
      eq_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_equal_q  <= rsp_equal_d;
      cmp_cnt_q    <= cmp_cnt_d;
      eq_cnt_q     <= eq_cnt_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_equal     = rsp_equal_q;
  assign busy          = (state_q != IDLE);
  assign compare_count = cmp_cnt_q;
  assign equal_count   = eq_cnt_q;

endmodule
